snake_body_engine: RTL



---
 rtl/snake_body_engine.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/snake_body_engine.sv
// Snake body controller: a shift-register body with the head at index 0.
// A step/collision FSM drives a square scanner that emits one VGA pixel per cycle.
module snake_body_engine #(
    parameter int           XSCREEN     = 160,
    parameter int           YSCREEN     = 120,
    parameter int           SEG         = 10,
    parameter int           MAX_LEN     = 8,
    parameter int           INIT_LEN    = 4,
    parameter int           X0          = 80,
    parameter int           Y0          = 60,
    parameter logic [2:0]   HEAD_COLOUR = 3'b010,
    parameter logic [2:0]   BODY_COLOUR = 3'b111,
    parameter logic [2:0]   BG_COLOUR   = 3'b000,
    parameter int           XW          = 8,
    parameter int           YW          = 7,
    parameter int           LW          = 4
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            start,
    input  logic            step,
    input  logic [1:0]      dir,
    input  logic            grow,
    output logic            busy,
    output logic            done,
    output logic            dead,
    output logic [LW-1:0]   length,
    output logic [XW-1:0]   head_x,
    output logic [YW-1:0]   head_y,
    output logic [XW-1:0]   vga_x,
    output logic [YW-1:0]   vga_y,
    output logic [2:0]      vga_colour,
    output logic            plot
);
    localparam int CW  = (SEG > 1) ? $clog2(SEG) : 1;
    localparam int IW  = $clog2(MAX_LEN);
    localparam int XW1 = XW + 1;
    localparam int YW1 = YW + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_INIT_DRAW, S_READY, S_CHECK, S_ERASE,
        S_SHIFT, S_RECOLOUR, S_DRAW_HEAD, S_DONE, S_DEAD
    } state_t;

    state_t                     state_q, state_d;
    logic [MAX_LEN-1:0][XW-1:0] seg_x_q, seg_x_d, init_x;
    logic [MAX_LEN-1:0][YW-1:0] seg_y_q, seg_y_d, init_y;
    logic [LW-1:0]              len_q, len_d, idx_q, idx_d;
    logic [1:0]                 heading_q, heading_d;
    logic                       grow_q, grow_d;
    logic [CW-1:0]              xc_q, xc_d, yc_q, yc_d;

    logic                       scanning, sq_end, shift_en, wall_hit, self_hit;
    logic [XW-1:0]              new_x;
    logic [YW-1:0]              new_y;
    logic [LW-1:0]              self_limit;
    logic [MAX_LEN-1:0]         hit_vec;
    logic [IW-1:0]              base_sel;
    logic [2:0]                 colour;

    assign scanning = (state_q == S_INIT_DRAW) || (state_q == S_ERASE) ||
                      (state_q == S_RECOLOUR)  || (state_q == S_DRAW_HEAD);
    assign sq_end   = (xc_q == CW'(SEG - 1)) && (yc_q == CW'(SEG - 1));

    // Counters sit at zero outside a scan, so every square starts at its corner.
    always_comb begin
        xc_d = '0;
        yc_d = '0;
        if (scanning) begin
            if (xc_q == CW'(SEG - 1)) begin
                yc_d = (yc_q == CW'(SEG - 1)) ? '0 : yc_q + CW'(1);
            end else begin
                xc_d = xc_q + CW'(1);
                yc_d = yc_q;
            end
        end
    end

    always_comb begin
        new_x    = seg_x_q[0];
        new_y    = seg_y_q[0];
        wall_hit = 1'b0;
        case (heading_q)
            2'b00: begin
                new_x    = seg_x_q[0] + XW'(SEG);
                wall_hit = ({1'b0, seg_x_q[0]} + XW1'(SEG)) > XW1'(XSCREEN - SEG);
            end
            2'b01: begin
                new_y    = seg_y_q[0] + YW'(SEG);
                wall_hit = ({1'b0, seg_y_q[0]} + YW1'(SEG)) > YW1'(YSCREEN - SEG);
            end
            2'b10: begin
                new_y    = seg_y_q[0] - YW'(SEG);
                wall_hit = seg_y_q[0] < YW'(SEG);
            end
            default: begin
                new_x    = seg_x_q[0] - XW'(SEG);
                wall_hit = seg_x_q[0] < XW'(SEG);
            end
        endcase
    end

    // The tail slot vacates during a plain move, so it cannot be bitten.
    assign self_limit = grow_q ? len_q : len_q - LW'(1);

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_seg
            if (gi < INIT_LEN) begin : g_live
                assign init_x[gi] = XW'(X0 - gi * SEG);
            end else begin : g_spare
                assign init_x[gi] = '0;
            end
            assign init_y[gi]  = YW'(Y0);
            assign hit_vec[gi] = (LW'(gi) < self_limit) &&
                                 (seg_x_q[gi] == new_x) && (seg_y_q[gi] == new_y);
            if (gi == 0) begin : g_head
                assign seg_x_d[gi] = shift_en ? new_x : seg_x_q[gi];
                assign seg_y_d[gi] = shift_en ? new_y : seg_y_q[gi];
            end else begin : g_body
                assign seg_x_d[gi] = shift_en ? seg_x_q[gi-1] : seg_x_q[gi];
                assign seg_y_d[gi] = shift_en ? seg_y_q[gi-1] : seg_y_q[gi];
            end
        end
    endgenerate

    assign self_hit = |hit_vec;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        heading_d = heading_q;
        grow_d    = grow_q;
        shift_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT_DRAW;
                    idx_d   = len_q - LW'(1);
                end
            end
            S_INIT_DRAW: begin
                if (sq_end) begin
                    if (idx_q == '0) state_d = S_READY;
                    else             idx_d   = idx_q - LW'(1);
                end
            end
            S_READY: begin
                if (step) begin
                    heading_d = (dir == ~heading_q) ? heading_q : dir;
                    grow_d    = grow && (len_q != LW'(MAX_LEN));
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (wall_hit || self_hit) state_d = S_DEAD;
                else if (grow_q)          state_d = S_SHIFT;
                else                      state_d = S_ERASE;
            end
            S_ERASE:     if (sq_end) state_d = S_SHIFT;
            S_SHIFT: begin
                shift_en = 1'b1;
                if (grow_q) len_d = len_q + LW'(1);
                state_d = S_RECOLOUR;
            end
            S_RECOLOUR:  if (sq_end) state_d = S_DRAW_HEAD;
            S_DRAW_HEAD: if (sq_end) state_d = S_DONE;
            S_DONE:      state_d = S_READY;
            default:     state_d = S_DEAD;
        endcase
    end

    always_comb begin
        base_sel = '0;
        colour   = '0;
        case (state_q)
            S_INIT_DRAW: begin
                base_sel = IW'(idx_q);
                colour   = (idx_q == '0) ? HEAD_COLOUR : BODY_COLOUR;
            end
            S_ERASE: begin
                base_sel = IW'(len_q - LW'(1));
                colour   = BG_COLOUR;
            end
            S_RECOLOUR: begin
                base_sel = IW'(1);
                colour   = BODY_COLOUR;
            end
            S_DRAW_HEAD: colour = HEAD_COLOUR;
            default: ;
        endcase
    end

    assign vga_x      = scanning ? seg_x_q[base_sel] + XW'(xc_q) : '0;
    assign vga_y      = scanning ? seg_y_q[base_sel] + YW'(yc_q) : '0;
    assign vga_colour = scanning ? colour : '0;
    assign plot       = scanning;
    assign busy       = scanning || (state_q == S_CHECK) || (state_q == S_SHIFT) ||
                        (state_q == S_DONE);
    assign done       = (state_q == S_DONE);
    assign dead       = (state_q == S_DEAD);
    assign length     = len_q;
    assign head_x     = seg_x_q[0];
    assign head_y     = seg_y_q[0];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            seg_x_q   <= init_x;
            seg_y_q   <= init_y;
            len_q     <= LW'(INIT_LEN);
            idx_q     <= '0;
            heading_q <= 2'b00;
            grow_q    <= 1'b0;
            xc_q      <= '0;
            yc_q      <= '0;
        end else begin
            state_q   <= state_d;
            seg_x_q   <= seg_x_d;
            seg_y_q   <= seg_y_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            heading_q <= heading_d;
            grow_q    <= grow_d;
            xc_q      <= xc_d;
            yc_q      <= yc_d;
        end
    end
endmodule
